truth_table_bist: RTL and testbench

//  Hardware stimulus/response engine for small combinational Boolean blocks.
//  - On start, walks every N_IN-bit input vector in ascending order, drives it to the DUT,

---
 rtl/bist_pkg.sv | 12 +
 rtl/truth_table_bist_if.sv | 20 ++
 rtl/tt_response_checker.sv | 39 +++
 rtl/truth_table_bist.sv | 71 +++++++
 tb/tb_truth_table_bist.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: FSM state encodings and the settle-counter width helper shared by the truth-table BIST
package bist_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  // Bits needed to count 0..n; never narrower than one bit so SETTLE_CYCLES = 0 still has a counter.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/truth_table_bist_if.sv
// truth_table_bist_if: request, DUT stimulus/response and result bundle of the truth-table BIST
//   start          request, sampled in IDLE
//   dut_in/dut_out vector driven to the checked block and its response
//   busy/done/pass sweep status; fail_count, first_fail_vec, captured_tt are the results
//   master: the side that requests sweeps and hosts the checked block; slave: the BIST
interface truth_table_bist_if #(parameter int N_IN = 3);
  logic                 start;
  logic [N_IN-1:0]      dut_in;
  logic                 dut_out;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        fail_count;
  logic [N_IN-1:0]      first_fail_vec;
  logic [2**N_IN-1:0]   captured_tt;
  modport master (output start, dut_out,
                  input  dut_in, busy, done, pass, fail_count, first_fail_vec, captured_tt);
  modport slave  (input  start, dut_out,
                  output dut_in, busy, done, pass, fail_count, first_fail_vec, captured_tt);
endinterface

// File: rtl/tt_response_checker.sv
// tt_response_checker: captures each sampled response and accumulates mismatch count and first failing vector
//   i_clear      drop all results (sweep accepted)
//   i_sample     record i_dut_out for vector i_vec and compare with i_expected
//   o_captured_tt, o_fail_count, o_first_fail_vec  accumulated results
module tt_response_checker #(
  parameter int N_IN = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_sample,
  input  logic [N_IN-1:0]     i_vec,
  input  logic                i_dut_out,
  input  logic                i_expected,
  output logic [2**N_IN-1:0]  o_captured_tt,
  output logic [N_IN:0]       o_fail_count,
  output logic [N_IN-1:0]     o_first_fail_vec
);
  logic [2**N_IN-1:0] r_tt;
  logic [N_IN:0]      r_fc;
  logic [N_IN-1:0]    r_ffv;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_clear) begin
      r_tt  <= '0;
      r_fc  <= '0;
      r_ffv <= '0;
    end else if (i_sample) begin
      r_tt[i_vec] <= i_dut_out;
      if (i_dut_out != i_expected) begin
        r_fc <= r_fc + 1'b1;
        // Vectors are walked in ascending order, so the first mismatch is the lowest index.
        if (r_fc == '0) r_ffv <= i_vec;
      end
    end
  end
  assign o_captured_tt    = r_tt;
  assign o_fail_count     = r_fc;
  assign o_first_fail_vec = r_ffv;
endmodule

// File: rtl/truth_table_bist.sv
// truth_table_bist: sweeps every input vector into a combinational block, samples after a settle window and checks it against EXPECTED
//   clk, rst  clock and asynchronous active-high reset
//   bus       slave side of truth_table_bist_if (start in, dut_in out, dut_out in, status and results out)
module truth_table_bist
  import bist_pkg::*;
#(
  parameter int                N_IN          = 3,
  parameter logic [2**N_IN-1:0] EXPECTED      = 8'hE8,
  parameter int                SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  truth_table_bist_if.slave  bus
);
  localparam int            CW = cnt_w(SETTLE_CYCLES);
  localparam logic [CW-1:0] SC = CW'(SETTLE_CYCLES);
  state_t             r_state, w_next;
  logic [N_IN-1:0]    r_vec;
  logic [CW-1:0]      r_cnt;
  logic               r_pass;
  logic               w_accept, w_sample, w_last_vec;
  logic [N_IN:0]      w_fail_count;
  assign w_accept   = (r_state == ST_IDLE) && bus.start;
  assign w_sample   = (r_state == ST_APPLY) && (r_cnt == SC);
  assign w_last_vec = (r_vec == '1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == ST_IDLE)  ? (bus.start ? ST_APPLY : ST_IDLE) :
             (r_state == ST_APPLY) ? ((w_sample && w_last_vec) ? ST_DONE : ST_APPLY) :
                                     ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec  <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_vec  <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (r_state == ST_APPLY) begin
      r_cnt <= w_sample ? '0 : r_cnt + 1'b1;
      // vec stays on the last vector so DONE keeps presenting it.
      if (w_sample && !w_last_vec) r_vec <= r_vec + 1'b1;
    end else if (r_state == ST_DONE) begin
      r_pass <= (w_fail_count == '0);
    end
  end
  tt_response_checker #(.N_IN(N_IN)) u_chk (
    .clk              (clk),
    .rst              (rst),
    .i_clear          (w_accept),
    .i_sample         (w_sample),
    .i_vec            (r_vec),
    .i_dut_out        (bus.dut_out),
    .i_expected       (EXPECTED[r_vec]),
    .o_captured_tt    (bus.captured_tt),
    .o_fail_count     (w_fail_count),
    .o_first_fail_vec (bus.first_fail_vec)
  );
  assign bus.fail_count = w_fail_count;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.dut_in     = (r_state == ST_IDLE) ? '0 : r_vec;
  // During DONE the registered pass flag is not yet loaded, so derive it from the final count.
  assign bus.pass       = (r_state == ST_DONE) ? (w_fail_count == '0) : r_pass;
endmodule

// File: tb/tb_truth_table_bist.sv
// tb_truth_table_bist: directed table-driven check of truth_table_bist against behavioural faulty/correct majority blocks
module tb_truth_table_bist;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   mode  = 0;
  always #5 clk = ~clk;
  truth_table_bist_if #(.N_IN(3)) m ();
  truth_table_bist_if #(.N_IN(3)) z ();
  truth_table_bist_if #(.N_IN(3)) t ();
  function automatic logic model(input int md, input logic [2:0] v);
    logic mj;
    mj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    return (md == 0) ? mj : (md == 1) ? 1'b0 : (md == 2) ? (mj ^ (v == 3'd5)) :
           (md == 3) ? 1'b1 : ~mj;
  endfunction
  assign m.dut_out = model(mode, m.dut_in);
  assign z.dut_out = model(0, z.dut_in);
  assign t.dut_out = model(0, t.dut_in);
  truth_table_bist #(.N_IN(3), .EXPECTED(8'hE8), .SETTLE_CYCLES(1)) u_main (.clk(clk), .rst(rst), .bus(m));
  truth_table_bist #(.N_IN(3), .EXPECTED(8'hE8), .SETTLE_CYCLES(0)) u_s0   (.clk(clk), .rst(rst), .bus(z));
  truth_table_bist #(.N_IN(3), .EXPECTED(8'hE8), .SETTLE_CYCLES(3)) u_s3   (.clk(clk), .rst(rst), .bus(t));
  typedef struct {
    int         mode;
    logic [7:0] tt;
    logic [3:0] fc;
    logic [2:0] ffv;
    logic       pass;
  } vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // Called on the first negedge after the accepting edge; returns edges elapsed until done.
  task automatic wait_main(output int c, output bit ok);
    c  = 0;
    ok = 1'b1;
    while (!m.done && c < 200) begin
      if (m.dut_in !== 3'(c / 2)) ok = 1'b0;
      @(negedge clk);
      c++;
    end
  endtask
  task automatic start_main();
    @(negedge clk);
    m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
  endtask
  initial begin
    int c, d0, d3;
    bit ok, ok0, ok3, seen;
    tbl[0] = '{0, 8'hE8, 4'd0, 3'd0, 1'b1};
    tbl[1] = '{1, 8'h00, 4'd4, 3'd3, 1'b0};
    tbl[2] = '{2, 8'hC8, 4'd1, 3'd5, 1'b0};
    tbl[3] = '{3, 8'hFF, 4'd4, 3'd0, 1'b0};
    tbl[4] = '{4, 8'h17, 4'd8, 3'd0, 1'b0};
    m.start = 1'b0;
    z.start = 1'b0;
    t.start = 1'b0;
    @(negedge clk);
    chk("rst_busy", m.busy, 0);
    chk("rst_done", m.done, 0);
    chk("rst_pass", m.pass, 0);
    chk("rst_tt", m.captured_tt, 0);
    chk("rst_fc", m.fail_count, 0);
    chk("rst_ffv", m.first_fail_vec, 0);
    chk("rst_dut_in", m.dut_in, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_pass", m.pass, 0);
    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      start_main();
      wait_main(c, ok);
      chk($sformatf("v%0d_latency", i), c, 16);
      chk($sformatf("v%0d_dut_in_seq", i), ok, 1);
      chk($sformatf("v%0d_busy_done", i), m.busy, 1);
      chk($sformatf("v%0d_dut_in_done", i), m.dut_in, 7);
      chk($sformatf("v%0d_tt", i), m.captured_tt, tbl[i].tt);
      chk($sformatf("v%0d_fc", i), m.fail_count, tbl[i].fc);
      chk($sformatf("v%0d_ffv", i), m.first_fail_vec, tbl[i].ffv);
      chk($sformatf("v%0d_pass", i), m.pass, tbl[i].pass);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), m.done, 0);
      chk($sformatf("v%0d_busy_idle", i), m.busy, 0);
      chk($sformatf("v%0d_dut_in_idle", i), m.dut_in, 0);
      chk($sformatf("v%0d_tt_hold", i), m.captured_tt, tbl[i].tt);
      chk($sformatf("v%0d_fc_hold", i), m.fail_count, tbl[i].fc);
      chk($sformatf("v%0d_pass_hold", i), m.pass, tbl[i].pass);
    end
    // Start pulse mid-sweep is ignored; start held through DONE relaunches back-to-back.
    mode = 2;
    start_main();
    c = 0;
    repeat (4) begin
      @(negedge clk);
      c++;
    end
    chk("b2b_vec2", m.dut_in, 2);
    m.start = 1'b1;
    @(negedge clk);
    c++;
    m.start = 1'b0;
    while (!m.done && c < 200) begin
      if (c == 14) m.start = 1'b1;
      @(negedge clk);
      c++;
    end
    chk("b2b_latency", c, 16);
    chk("b2b_tt", m.captured_tt, 8'hC8);
    chk("b2b_fc", m.fail_count, 1);
    chk("b2b_ffv", m.first_fail_vec, 5);
    @(negedge clk);
    chk("b2b_idle_busy", m.busy, 0);
    chk("b2b_idle_fc", m.fail_count, 1);
    @(negedge clk);
    m.start = 1'b0;
    chk("b2b_rerun_busy", m.busy, 1);
    chk("b2b_clr_tt", m.captured_tt, 0);
    chk("b2b_clr_fc", m.fail_count, 0);
    chk("b2b_clr_ffv", m.first_fail_vec, 0);
    wait_main(c, ok);
    chk("b2b2_latency", c, 16);
    chk("b2b2_seq", ok, 1);
    chk("b2b2_tt", m.captured_tt, 8'hC8);
    chk("b2b2_fc", m.fail_count, 1);
    chk("b2b2_ffv", m.first_fail_vec, 5);
    chk("b2b2_pass", m.pass, 0);
    // Asynchronous reset while vector 3 is applied.
    mode = 3;
    start_main();
    repeat (6) @(negedge clk);
    chk("ar_vec3", m.dut_in, 3);
    chk("ar_pre_tt", m.captured_tt, 8'h07);
    chk("ar_pre_fc", m.fail_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", m.busy, 0);
    chk("ar_dut_in", m.dut_in, 0);
    chk("ar_tt", m.captured_tt, 0);
    chk("ar_fc", m.fail_count, 0);
    chk("ar_done", m.done, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m.done || m.busy) seen = 1'b1;
    end
    chk("ar_no_done", seen, 0);
    mode = 0;
    start_main();
    wait_main(c, ok);
    chk("ar_rerun_latency", c, 16);
    chk("ar_rerun_tt", m.captured_tt, 8'hE8);
    chk("ar_rerun_pass", m.pass, 1);
    // Settle window 0 and 3 run side by side.
    @(negedge clk);
    z.start = 1'b1;
    t.start = 1'b1;
    @(negedge clk);
    z.start = 1'b0;
    t.start = 1'b0;
    c = 0;
    d0 = -1;
    d3 = -1;
    ok0 = 1'b1;
    ok3 = 1'b1;
    while ((d0 < 0 || d3 < 0) && c < 200) begin
      if (d0 < 0) begin
        if (z.done) begin
          d0 = c;
          chk("s0_tt", z.captured_tt, 8'hE8);
          chk("s0_fc", z.fail_count, 0);
          chk("s0_pass", z.pass, 1);
        end else if (z.dut_in !== 3'(c)) ok0 = 1'b0;
      end
      if (d3 < 0) begin
        if (t.done) begin
          d3 = c;
          chk("s3_tt", t.captured_tt, 8'hE8);
          chk("s3_fc", t.fail_count, 0);
          chk("s3_pass", t.pass, 1);
        end else if (t.dut_in !== 3'(c / 4)) ok3 = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    chk("s0_latency", d0, 8);
    chk("s3_latency", d3, 32);
    chk("s0_hold", ok0, 1);
    chk("s3_hold", ok3, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
